wb_rr_arbiter: RTL

// - N-port Wishbone (pipelined, B4) round-robin arbiter in front of the single memory/bus master port.
// - Generalises the fixed 2-port memory mux: fair rotating priority, registered grant, per-cycle lock.
// - Caps outstanding pipelined requests on the shared port.
// - Sits between fetch/LSU/debug requesters and the external memory interface.

---
 rtl/wb_rr_arbiter_if.sv | 25 ++
 rtl/wb_rr_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/wb_rr_arbiter_if.sv
// Pipelined Wishbone B4 bundle with N_LANES ports packed side by side
// (lane i at adr/wdat/rdat[i*32+:32], sel[i*4+:4], scalar bits at [i]).
interface wb_rr_arbiter_if #(
  parameter int N_LANES = 1
) ();
  logic [N_LANES*32-1:0] adr;
  logic [N_LANES*32-1:0] wdat;
  logic [N_LANES*32-1:0] rdat;
  logic [N_LANES-1:0]    we;
  logic [N_LANES*4-1:0]  sel;
  logic [N_LANES-1:0]    stb;
  logic [N_LANES-1:0]    cyc;
  logic [N_LANES-1:0]    ack;
  logic [N_LANES-1:0]    stall;

  modport master (
    output adr, wdat, we, sel, stb, cyc,
    input  rdat, ack, stall
  );

  modport slave (
    input  adr, wdat, we, sel, stb, cyc,
    output rdat, ack, stall
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// N-port pipelined Wishbone round-robin arbiter with an outstanding-request cap.
// Optional watchdog with requester lockout is enabled by defining WB_ARB_TIMEOUT_EN.
module wb_rr_arbiter #(
  parameter int N_PORTS         = 2,
  parameter int MAX_OUTSTANDING = 4
`ifdef WB_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES  = 255
`endif
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  wb_rr_arbiter_if.slave  s_wb,
  wb_rr_arbiter_if.master m_wb
`ifdef WB_ARB_TIMEOUT_EN
  ,
  output logic           timeout_o
`endif
);

  localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t             state_r;
  logic [PTR_W-1:0]   rr_ptr_r;
  logic [PTR_W-1:0]   grant_r;
  logic [PTR_W-1:0]   grant_next_s;
  logic [CNT_W-1:0]   outstanding_r;
  logic [CNT_W-1:0]   outstanding_next_s;
  logic [N_PORTS-1:0] req_s;
  logic               room_s;
  logic               m_stb_s;
  logic               inc_s;
  logic               dec_s;
  logic               tmo_hit_s;

  // First requesting port found scanning ptr, ptr+1, ... modulo N_PORTS.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [N_PORTS-1:0] req,
                                               input logic [PTR_W-1:0]   ptr);
    logic [PTR_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < N_PORTS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_PORTS) begin
        idx = idx - N_PORTS;
      end else begin
        idx = idx;
      end
      if (!found && req[idx]) begin
        pick  = idx[PTR_W-1:0];
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(N_PORTS - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign room_s = (outstanding_r < CNT_W'(MAX_OUTSTANDING));

`ifdef WB_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0]   tmo_cnt_r;
  logic [N_PORTS-1:0] lock_r;
  logic               timeout_r;
  logic               tmo_run_s;

  // The watchdog only measures time spent waiting on a silent slave.
  assign tmo_run_s = (state_r == ST_BUSY) && (outstanding_r != {CNT_W{1'b0}}) && !m_wb.ack[0];
  assign tmo_hit_s = tmo_run_s && s_wb.cyc[grant_r] &&
                     (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1));
  assign req_s     = s_wb.cyc & s_wb.stb & ~lock_r;
  assign timeout_o = timeout_r;

  // Watchdog counter, timeout pulse and per-port lockout (held until the port drops cyc).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
      lock_r    <= {N_PORTS{1'b0}};
      timeout_r <= 1'b0;
    end else begin
      if (tmo_hit_s) begin
        tmo_cnt_r <= {TMO_W{1'b0}};
        lock_r    <= (lock_r & s_wb.cyc) | (N_PORTS'(1) << grant_r);
        timeout_r <= 1'b1;
      end else if (tmo_run_s) begin
        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        lock_r    <= lock_r & s_wb.cyc;
        timeout_r <= 1'b0;
      end else begin
        tmo_cnt_r <= {TMO_W{1'b0}};
        lock_r    <= lock_r & s_wb.cyc;
        timeout_r <= 1'b0;
      end
    end
  end
`else
  assign tmo_hit_s = 1'b0;
  assign req_s     = s_wb.cyc & s_wb.stb;
`endif

  assign grant_next_s = rr_pick(req_s, rr_ptr_r);

  // Request/response routing; everything idles (stalls high) unless a port holds the grant.
  always_comb begin
    m_wb.adr   = 32'h0;
    m_wb.wdat  = 32'h0;
    m_wb.we    = 1'b0;
    m_wb.sel   = 4'h0;
    m_wb.cyc   = 1'b0;
    m_stb_s    = 1'b0;
    s_wb.stall = {N_PORTS{1'b1}};
    s_wb.ack   = {N_PORTS{1'b0}};
    s_wb.rdat  = {(N_PORTS*32){1'b0}};
    if (state_r == ST_BUSY) begin
      m_wb.adr   = s_wb.adr[int'(grant_r)*32 +: 32];
      m_wb.wdat  = s_wb.wdat[int'(grant_r)*32 +: 32];
      m_wb.we    = s_wb.we[grant_r];
      m_wb.sel   = s_wb.sel[int'(grant_r)*4 +: 4];
      m_wb.cyc   = s_wb.cyc[grant_r];
      m_stb_s    = s_wb.stb[grant_r] & room_s;
      s_wb.stall[grant_r] = m_wb.stall[0] | ~room_s;
      s_wb.ack[grant_r]   = m_wb.ack[0];
      s_wb.rdat[int'(grant_r)*32 +: 32] = m_wb.rdat;
    end else begin
      m_stb_s = 1'b0;
    end
    m_wb.stb = m_stb_s;
  end

  // Outstanding count update; an ack with nothing outstanding is ignored.
  always_comb begin
    inc_s = m_stb_s & ~m_wb.stall[0];
    dec_s = m_wb.ack[0] & (outstanding_r != {CNT_W{1'b0}});
    case ({inc_s, dec_s})
      2'b10:   outstanding_next_s = outstanding_r + CNT_W'(1);
      2'b01:   outstanding_next_s = outstanding_r - CNT_W'(1);
      default: outstanding_next_s = outstanding_r;
    endcase
  end

  // Arbitration FSM: grant on IDLE, hold for the whole cyc, rotate pointer on release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r       <= ST_IDLE;
      rr_ptr_r      <= {PTR_W{1'b0}};
      grant_r       <= {PTR_W{1'b0}};
      outstanding_r <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          outstanding_r <= {CNT_W{1'b0}};
          if (|req_s) begin
            grant_r <= grant_next_s;
            state_r <= ST_BUSY;
          end else begin
            grant_r <= grant_r;
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          // Dropping cyc aborts the cycle; acks still in flight are no longer routed.
          if (!s_wb.cyc[grant_r] || tmo_hit_s) begin
            state_r       <= ST_IDLE;
            outstanding_r <= {CNT_W{1'b0}};
            rr_ptr_r      <= ptr_inc(grant_r);
          end else begin
            state_r       <= ST_BUSY;
            outstanding_r <= outstanding_next_s;
          end
        end
        default: begin
          state_r       <= ST_IDLE;
          outstanding_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

endmodule
